// File: rtl/adder_scheduler_pkg.sv
// Shared types and helpers for schedulers that time-share an arithmetic unit.
package adder_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first request after last_grant wins,
// scanning upward with wrap.
module rr_arbiter
  import adder_scheduler_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = id_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/adder_scheduler.sv
// Shares one adder among NUM_REQ requesters: grant round-robin, capture the
// operand vector, sum it serially and hold the result until it is taken.
module adder_scheduler
  import adder_scheduler_pkg::*;
#(
  parameter int NUM_BITS = 32,
  parameter int NUM_SUMS = 4,
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = id_width(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*NUM_SUMS*NUM_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 res_valid,
  output logic [NUM_BITS-1:0]                  res_data,
  output logic [ID_W-1:0]                      res_id,
  input  logic                                 res_ready
);

  localparam int IDX_W = id_width(NUM_SUMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SUMS - 1);

  sched_state_t          state;
  logic [NUM_BITS-1:0]   op_buf [NUM_SUMS];
  logic [NUM_BITS-1:0]   acc;
  logic [NUM_BITS-1:0]   acc_next;
  logic [IDX_W-1:0]      idx;
  logic [ID_W-1:0]       id;
  logic [ID_W-1:0]       last_grant;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // rst gates the grant so nothing is accepted while reset is held
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign acc_next  = acc + op_buf[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      idx        <= '0;
      id         <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= '0;
      for (int k = 0; k < NUM_SUMS; k++) op_buf[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            for (int k = 0; k < NUM_SUMS; k++)
              op_buf[k] <= req_data[(int'(grant_idx) * NUM_SUMS + k) * NUM_BITS +: NUM_BITS];
            acc        <= req_data[int'(grant_idx) * NUM_SUMS * NUM_BITS +: NUM_BITS];
            id         <= grant_idx;
            last_grant <= grant_idx;
            idx        <= IDX_W'(1);
            if (NUM_SUMS > 1) begin
              state <= ACCUM;
            end else begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_data  <= req_data[int'(grant_idx) * NUM_SUMS * NUM_BITS +: NUM_BITS];
              res_id    <= grant_idx;
            end
          end
        end
        ACCUM: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_data  <= acc_next;
            res_id    <= id;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_scheduler.sv
// Scoreboard bench for adder_scheduler: a reference model predicts grants and
// sums; a negedge monitor compares them with what the DUT presents.
module tb_adder_scheduler;

  localparam int NB = 32;
  localparam int NS = 4;
  localparam int NR = 4;

  logic                  clk;
  logic                  rst;
  logic [NR-1:0]         req_valid;
  logic [NR*NS*NB-1:0]   req_data;
  logic [NR-1:0]         req_ready;
  logic                  res_valid;
  logic [NB-1:0]         res_data;
  logic [1:0]            res_id;
  logic                  res_ready;

  logic                  s_req_valid;
  logic [NB-1:0]         s_req_data;
  logic                  s_req_ready;
  logic                  s_res_valid;
  logic [NB-1:0]         s_res_data;
  logic                  s_res_id;
  logic                  s_res_ready;

  adder_scheduler #(.NUM_BITS(NB), .NUM_SUMS(NS), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
    .res_id(res_id), .res_ready(res_ready)
  );

  adder_scheduler #(.NUM_BITS(NB), .NUM_SUMS(1), .NUM_REQ(1)) dut_small (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_data(s_req_data),
    .req_ready(s_req_ready), .res_valid(s_res_valid), .res_data(s_res_data),
    .res_id(s_res_id), .res_ready(s_res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [NB-1:0] sum; int id; int due;} exp_t;
  typedef struct {int id; int cyc;} gl_t;

  exp_t          q[$];
  gl_t           glog[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  bit            busy = 0;
  int            last_g = NR - 1;
  logic [NR-1:0] granted = '0;
  logic [NR-1:0] pend;
  bit            persist = 0;
  bit            rand_on = 0;
  logic [NB-1:0] ops [NR][NS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and reference model
  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    logic [NB-1:0] s;
    int g;
    if (rst) begin
      q.delete();
      busy   = 0;
      last_g = NR - 1;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (!busy)
        for (int k = 1; k <= NR; k++)
          if (g < 0 && req_valid[(last_g + k) % NR]) g = (last_g + k) % NR;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      for (int i = 0; i < NR; i++)
        if (req_ready[i]) glog.push_back('{i, cyc});
      if (q.size() > 0 && cyc >= q[0].due) begin
        chk("res_valid", 64'(res_valid), 64'd1);
        chk("res_data", 64'(res_data), 64'(q[0].sum));
        chk("res_id", 64'(res_id), 64'(q[0].id));
        if (res_valid && res_ready) begin
          void'(q.pop_front());
          busy = 0;
        end
      end else begin
        chk("res_valid_low", 64'(res_valid), 64'd0);
      end
      if (g >= 0) begin
        s = '0;
        for (int k = 0; k < NS; k++) s = s + req_data[(g * NS + k) * NB +: NB];
        q.push_back('{s, g, cyc + NS});
        busy       = 1;
        last_g     = g;
        granted[g] = 1'b1;
      end
    end
  end

  function automatic logic [NB-1:0] rand_op();
    return ($urandom_range(0, 3) == 0) ? {NB{1'b1}} : NB'($urandom);
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = pend[i];
      for (int k = 0; k < NS; k++) req_data[(i * NS + k) * NB +: NB] = ops[i][k];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (granted[i]) begin
        granted[i] = 1'b0;
        pend[i]    = persist;
        for (int k = 0; k < NS; k++) ops[i][k] = rand_op();
      end
    if (rand_on) begin
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          for (int k = 0; k < NS; k++) ops[i][k] = rand_op();
        end else if (pend[i] && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
        end
      end
    end
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    persist   = 0;
    res_ready = 1'b1;
    while (((|pend) || busy || q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(n < budget), 64'd1);
  endtask

  initial begin
    int n;
    int c0;
    rst = 1'b1; res_ready = 1'b1; pend = '0;
    s_req_valid = 1'b0; s_req_data = '0; s_res_ready = 1'b1;
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < NS; k++) ops[i][k] = '0;
    drive();
    #2;
    pend = '1;
    drive();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    pend = '0;
    drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-operand, single-requester instance
    s_req_data = 32'h1234; s_req_valid = 1'b1;
    @(negedge clk);
    chk("s_req_ready", 64'(s_req_ready), 64'd1);
    chk("s_res_valid_T", 64'(s_res_valid), 64'd0);
    @(posedge clk); #1;
    s_req_valid = 1'b0; s_req_data = 32'hDEAD;
    @(negedge clk);
    chk("s_res_valid_T1", 64'(s_res_valid), 64'd1);
    chk("s_res_data", 64'(s_res_data), 64'h1234);
    chk("s_res_id", 64'(s_res_id), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("s_res_valid_drop", 64'(s_res_valid), 64'd0);
    @(posedge clk); #1;

    // Operands 1,2,3,4 from requester 0, then a wrapping sum from requester 3
    ops[0][0] = 1; ops[0][1] = 2; ops[0][2] = 3; ops[0][3] = 4;
    pend = 4'b0001;
    drive();
    drain(50);
    ops[3][0] = 32'hFFFF_FFFF; ops[3][1] = 1; ops[3][2] = 0; ops[3][3] = 5;
    pend = 4'b1000;
    drive();
    drain(50);

    // All requesters continuously valid: rotation and 5-cycle spacing
    glog.delete();
    persist = 1; pend = '1;
    drive();
    repeat (22) tick();
    persist = 0; pend = '0;
    drive();
    chk("rot_count", 64'(glog.size() >= 5), 64'd1);
    if (glog.size() >= 5)
      for (int k = 0; k < 5; k++) begin
        chk("rot_order", 64'(glog[k].id), 64'(k % NR));
        if (k > 0) chk("rot_spacing", 64'(glog[k].cyc - glog[k-1].cyc), 64'(NS + 1));
      end
    drain(50);

    // Stall in DONE for 10 cycles with every requester waiting
    res_ready = 1'b0; persist = 1; pend = '1;
    drive();
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    chk("stall_reached", 64'(res_valid), 64'd1);
    repeat (10) tick();
    glog.delete();
    res_ready = 1'b1;
    c0 = cyc;
    tick();
    tick();
    chk("resume_cycle", 64'(glog.size() > 0 ? glog[0].cyc : -1), 64'(c0 + 1));
    persist = 0; pend = '0;
    drive();
    drain(50);

    // Reset while accumulating
    for (int k = 0; k < NS; k++) ops[1][k] = rand_op();
    pend = 4'b0010;
    drive();
    tick();
    pend = '1;
    drive();
    rst = 1'b1;
    #1;
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk("arst_res_data", 64'(res_data), 64'd0);
    chk("arst_res_id", 64'(res_id), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0;
    glog.delete();
    tick();
    tick();
    chk("arst_first_grant", 64'(glog.size() > 0 ? glog[0].id : -1), 64'd0);
    pend = '0;
    drive();
    drain(50);

    // Randomised traffic with random back-pressure and withdrawals
    rand_on = 1;
    repeat (400) tick();
    rand_on = 0;
    drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
